bp_be_dcache_lce_req_arbiter: RTL and testbench

Shares the dcache's single LCE-to-CCE request channel between two requesters: the miss/uncached-load handler (port 0) and the uncached-store buffer (port 1). It arbitrates round-robin and registers the winner in a one-entry output stage. It meters outstanding requests with a credit counter and reports when all credits are home, which is used for fence/drain. It sits between the dcache LCE request logic and the LCE request network interface.

---
 rtl/bp_be_dcache_lce_req_arbiter_if.sv | 30 +++
 rtl/bp_be_dcache_lce_req_arbiter.sv | 75 +++++++
 tb/tb_bp_be_dcache_lce_req_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_dcache_lce_req_arbiter_if.sv
// bp_be_dcache_lce_req_arbiter_if: request, network and credit signals of the dcache LCE request arbiter
// Signals:
//   req_i / req_v_i / req_ready_o          - two requester payloads (slot i = requester i), valids, accepts
//   lce_req_o / lce_req_v_o / lce_req_ready_i - registered request toward the LCE request network
//   credit_return_i                         - one credit returned this cycle
//   credits_avail_o / credits_empty_o / credit_cnt_o - credit status
// Modports: slave = arbiter, master = requesters plus network side.
interface bp_be_dcache_lce_req_arbiter_if
  #(parameter int lce_cce_req_width_p = 128
   ,parameter int credits_p = 8
   ,localparam int credit_width_lp = (credits_p + 1 <= 1) ? 1 : $clog2(credits_p + 1));
   logic [2*lce_cce_req_width_p-1:0] req_i;
   logic [1:0]                       req_v_i;
   logic [1:0]                       req_ready_o;
   logic [lce_cce_req_width_p-1:0]   lce_req_o;
   logic                             lce_req_v_o;
   logic                             lce_req_ready_i;
   logic                             credit_return_i;
   logic                             credits_avail_o;
   logic                             credits_empty_o;
   logic [credit_width_lp-1:0]       credit_cnt_o;
   modport slave (
      input  req_i, req_v_i, lce_req_ready_i, credit_return_i,
      output req_ready_o, lce_req_o, lce_req_v_o, credits_avail_o, credits_empty_o, credit_cnt_o
   );
   modport master (
      output req_i, req_v_i, lce_req_ready_i, credit_return_i,
      input  req_ready_o, lce_req_o, lce_req_v_o, credits_avail_o, credits_empty_o, credit_cnt_o
   );
endinterface

// File: rtl/bp_be_dcache_lce_req_arbiter.sv
// bp_be_dcache_lce_req_arbiter: round-robin arbiter of two LCE requesters into a one-entry registered stage, with credit metering
// Ports:
//   clk_i   - clock, all state updates on the rising edge
//   reset_i - asynchronous active-high reset
//   io      - slave side of bp_be_dcache_lce_req_arbiter_if (requester handshakes, network handshake, credits)
module bp_be_dcache_lce_req_arbiter
  #(parameter int lce_cce_req_width_p = 128
   ,parameter int credits_p = 8
   ,localparam int credit_width_lp = (credits_p + 1 <= 1) ? 1 : $clog2(credits_p + 1))
   (input logic                          clk_i
   ,input logic                          reset_i
   ,bp_be_dcache_lce_req_arbiter_if.slave io);

   localparam int w_lp = lce_cce_req_width_p;

   logic [w_lp-1:0]            lce_req_q, lce_req_d;
   logic                       lce_req_v_q, lce_req_v_d;
   logic                       last_grant_q, last_grant_d;
   logic [credit_width_lp-1:0] credit_cnt_q, credit_cnt_d;
   logic [1:0]                 grant;
   logic                       stage_free, can_cap, capture, winner, overflow;

   // The stage may be refilled in the same cycle it drains to the network.
   assign stage_free = ~lce_req_v_q | io.lce_req_ready_i;
   assign can_cap    = stage_free & (credit_cnt_q != '0);

   // With both valid, the requester that did not win the last capture goes first.
   assign grant[0] = io.req_v_i[0] & (~io.req_v_i[1] | last_grant_q);
   assign grant[1] = io.req_v_i[1] & (~io.req_v_i[0] | ~last_grant_q);

   // Grants already imply valid, so any ready bit is a capture.
   assign io.req_ready_o = grant & {2{can_cap & ~reset_i}};
   assign capture        = |io.req_ready_o;
   assign winner         = grant[1];

   // A return with a full counter and no capture would exceed credits_p; the count saturates instead.
   assign overflow = io.credit_return_i & ~capture & (credit_cnt_q == credit_width_lp'(credits_p));

   always_comb begin
      lce_req_d    = capture ? (winner ? io.req_i[w_lp+:w_lp] : io.req_i[0+:w_lp]) : lce_req_q;
      lce_req_v_d  = capture | (lce_req_v_q & ~io.lce_req_ready_i);
      last_grant_d = capture ? winner : last_grant_q;
      credit_cnt_d = overflow ? credit_cnt_q
                   : credit_cnt_q - credit_width_lp'(capture) + credit_width_lp'(io.credit_return_i);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         lce_req_q    <= '0;
         lce_req_v_q  <= 1'b0;
         last_grant_q <= 1'b1;
         credit_cnt_q <= credit_width_lp'(credits_p);
      end else begin
         lce_req_q    <= lce_req_d;
         lce_req_v_q  <= lce_req_v_d;
         last_grant_q <= last_grant_d;
         credit_cnt_q <= credit_cnt_d;
      end
   end

   assign io.lce_req_o       = lce_req_q;
   assign io.lce_req_v_o     = lce_req_v_q;
   assign io.credit_cnt_o    = credit_cnt_q;
   assign io.credits_avail_o = credit_cnt_q != '0;
   assign io.credits_empty_o = (credit_cnt_q == credit_width_lp'(credits_p)) & ~lce_req_v_q;

   // Simulation-only protocol checks: requests must be held stable until accepted, and credits never overflow.
   for (genvar i = 0; i < 2; i++) begin : g_hold
      assert property (@(posedge clk_i) disable iff (reset_i)
         (io.req_v_i[i] && !io.req_ready_o[i]) |=> (io.req_v_i[i] && $stable(io.req_i[i*w_lp+:w_lp])));
   end

   assert property (@(posedge clk_i) disable iff (reset_i) !overflow);

endmodule

// File: tb/tb_bp_be_dcache_lce_req_arbiter.sv
// tb_bp_be_dcache_lce_req_arbiter: directed self-checking bench for the dcache LCE request arbiter
module tb_bp_be_dcache_lce_req_arbiter;
   localparam int W = 128;
   localparam int C = 8;

   logic clk_i = 1'b0;
   logic reset_i;
   always #5 clk_i = ~clk_i;

   bp_be_dcache_lce_req_arbiter_if #(.lce_cce_req_width_p(W), .credits_p(C)) io ();

   bp_be_dcache_lce_req_arbiter #(.lce_cce_req_width_p(W), .credits_p(C)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .io      (io.slave)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] p0, p1, exp_req;
   int win;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input logic [1:0] v);
      io.req_v_i = v;
      io.req_i   = {p1, p0};
   endtask

   initial begin
      // Reset state, with requester 0 already presenting A.
      reset_i = 1'b1;
      io.lce_req_ready_i = 1'b1;
      io.credit_return_i = 1'b0;
      p0 = 'hA0;
      p1 = 'hA1;
      set_req(2'b01);
      #2;
      chk("rst_v", io.lce_req_v_o, 0);
      chk("rst_req", io.lce_req_o, 0);
      chk("rst_cnt", io.credit_cnt_o, 8);
      chk("rst_empty", io.credits_empty_o, 1);
      chk("rst_ready", io.req_ready_o, 2'b00);
      tick();
      reset_i = 1'b0;
      #1;

      // Single requester: accepted in cycle 0, output valid in cycle 1.
      chk("t1_ready", io.req_ready_o, 2'b01);
      tick();
      chk("t1_v", io.lce_req_v_o, 1);
      chk("t1_req", io.lce_req_o, 'hA0);
      chk("t1_cnt", io.credit_cnt_o, 7);

      // Both valid every cycle with a credit back each cycle; requester 0 just won, so 1 goes first.
      p0 = 'hB0;
      p1 = 'hB1;
      set_req(2'b11);
      io.credit_return_i = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         win = (k % 2 == 0) ? 1 : 0;
         exp_req = win ? p1 : p0;
         chk($sformatf("rr_ready%0d", k), io.req_ready_o, win ? 2'b10 : 2'b01);
         tick();
         chk($sformatf("rr_v%0d", k), io.lce_req_v_o, 1);
         chk($sformatf("rr_req%0d", k), io.lce_req_o, exp_req);
         chk($sformatf("rr_cnt%0d", k), io.credit_cnt_o, 7);
         if (win) p1 = p1 + 'h10; else p0 = p0 + 'h10;
         set_req(2'b11);
         #1;
      end

      // Network back-pressure for 5 cycles: the held request must not move.
      io.credit_return_i = 1'b0;
      io.lce_req_ready_i = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_ready%0d", k), io.req_ready_o, 2'b00);
         chk($sformatf("bp_req%0d", k), io.lce_req_o, exp_req);
         chk($sformatf("bp_v%0d", k), io.lce_req_v_o, 1);
         tick();
      end
      chk("bp_cnt", io.credit_cnt_o, 7);
      io.lce_req_ready_i = 1'b1;
      #1;
      chk("bp_rel_ready", io.req_ready_o, 2'b10);
      tick();
      chk("bp_rel_req", io.lce_req_o, p1);
      chk("bp_rel_v", io.lce_req_v_o, 1);
      chk("bp_rel_cnt", io.credit_cnt_o, 6);
      set_req(2'b01);
      #1;
      chk("bp_p0_ready", io.req_ready_o, 2'b01);
      tick();
      chk("bp_p0_req", io.lce_req_o, p0);
      chk("bp_p0_cnt", io.credit_cnt_o, 5);
      set_req(2'b00);
      tick();
      chk("drain_v", io.lce_req_v_o, 0);

      // Refill to 8, then exhaust all credits with no returns.
      io.credit_return_i = 1'b1;
      tick();
      tick();
      tick();
      io.credit_return_i = 1'b0;
      chk("full_cnt", io.credit_cnt_o, 8);
      chk("full_empty", io.credits_empty_o, 1);
      p0 = 'hC00;
      set_req(2'b01);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("ex_ready%0d", k), io.req_ready_o, 2'b01);
         tick();
         chk($sformatf("ex_req%0d", k), io.lce_req_o, p0);
         chk($sformatf("ex_cnt%0d", k), io.credit_cnt_o, 7 - k);
         p0 = p0 + 1;
         set_req(2'b01);
      end
      #1;
      chk("ex_avail", io.credits_avail_o, 0);
      chk("ex_ready_none", io.req_ready_o, 2'b00);
      chk("ex_v", io.lce_req_v_o, 1);
      tick();
      chk("ex_v_drain", io.lce_req_v_o, 0);
      chk("ex_ready_still", io.req_ready_o, 2'b00);
      io.credit_return_i = 1'b1;
      #1;
      chk("ret_same_cycle", io.req_ready_o, 2'b00);
      tick();
      io.credit_return_i = 1'b0;
      #1;
      chk("ret_cnt", io.credit_cnt_o, 1);
      chk("ret_ready", io.req_ready_o, 2'b01);
      tick();
      chk("ret_req", io.lce_req_o, p0);
      chk("ret_cnt0", io.credit_cnt_o, 0);
      set_req(2'b00);

      // Capture and return together at count 3, then return the rest.
      io.credit_return_i = 1'b1;
      tick();
      tick();
      tick();
      chk("c3_cnt", io.credit_cnt_o, 3);
      p0 = 'hD0;
      set_req(2'b01);
      #1;
      chk("c3_ready", io.req_ready_o, 2'b01);
      tick();
      chk("c3_cnt_same", io.credit_cnt_o, 3);
      chk("c3_req", io.lce_req_o, 'hD0);
      set_req(2'b00);
      tick();
      chk("c3_not_empty", io.credits_empty_o, 0);
      tick();
      tick();
      tick();
      tick();
      io.credit_return_i = 1'b0;
      chk("drained_cnt", io.credit_cnt_o, 8);
      chk("drained_empty", io.credits_empty_o, 1);
      chk("drained_avail", io.credits_avail_o, 1);

      // Six captures to reach count 2 with the output held, then reset mid-cycle.
      p0 = 'hE0;
      set_req(2'b01);
      for (int k = 0; k < 6; k++) begin
         tick();
         p0 = p0 + 1;
         set_req(2'b01);
      end
      set_req(2'b00);
      io.lce_req_ready_i = 1'b0;
      #1;
      chk("pre_rst_cnt", io.credit_cnt_o, 2);
      chk("pre_rst_v", io.lce_req_v_o, 1);
      #2;
      reset_i = 1'b1;
      #1;
      chk("arst_v", io.lce_req_v_o, 0);
      chk("arst_req", io.lce_req_o, 0);
      chk("arst_cnt", io.credit_cnt_o, 8);
      chk("arst_ready", io.req_ready_o, 2'b00);
      #3;
      reset_i = 1'b0;
      io.lce_req_ready_i = 1'b1;
      p0 = 'hF0;
      p1 = 'hF1;
      set_req(2'b11);
      #1;
      chk("post_rst_ready", io.req_ready_o, 2'b01);
      chk("post_rst_cnt", io.credit_cnt_o, 8);
      tick();
      chk("post_rst_req", io.lce_req_o, 'hF0);
      chk("post_rst_cnt7", io.credit_cnt_o, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
